spi_master_multi: RTL and testbench
===================================

SPI_MASTER_MULTI -- requirements
Module: spi_master_multi

Interface
REQ-001 SHALL have parameter DATA_W, default 8: bits per transfer, legal range 4..32.
REQ-002 SHALL have parameter NUM_SS, default 2: number of slave-select lines, legal range 1..8.
REQ-003 SHALL have parameter CLKDIV, default 4: clk_clk cycles per SCLK half-period, minimum 1.
REQ-004 SHALL have clk_clk, input, 1: sole clock; all logic on rising edge.
REQ-005 SHALL have reset_reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have start, input, 1: one-cycle transfer request.
REQ-007 SHALL have tx_data, input, DATA_W: word to send.
REQ-008 SHALL have ss_sel, input, clog2(NUM_SS) (min 1): slave index.
REQ-009 SHALL have cpol, input, 1 and cpha, input, 1: SPI mode for this transfer.
REQ-010 SHALL have busy, output, 1: transfer in progress.
REQ-011 SHALL have done, output, 1: one-cycle completion pulse.
REQ-012 SHALL have err, output, 1: one-cycle pulse on a rejected request.
REQ-013 SHALL have rx_data, output, DATA_W: last received word.
REQ-014 SHALL have spi0_SCLK, output, 1; spi0_MOSI, output, 1; spi0_MISO, input, 1; spi0_SS_n, output, NUM_SS (active-low).

Function
REQ-015 SHALL implement states IDLE, LEAD, SHIFT, TRAIL, DONE.
REQ-016 In IDLE, start=1 with ss_sel<NUM_SS SHALL latch tx_data/ss_sel/cpol/cpha and enter LEAD; busy=1 and spi0_SS_n[ss_sel]=0 from the next cycle.
REQ-017 In IDLE, start=1 with ss_sel>=NUM_SS SHALL pulse err for one cycle, stay IDLE, leave SPI pins unchanged.
REQ-018 start SHALL be ignored when busy=1 (no err, no effect on the transfer).
REQ-019 LEAD SHALL last CLKDIV cycles with SCLK at latched cpol.
REQ-020 SHIFT SHALL generate 2*DATA_W SCLK edges, one every CLKDIV cycles, first edge at the end of LEAD; SCLK returns to cpol after the last edge.
REQ-021 Data SHALL be MSB first; exactly DATA_W bits shifted each direction.
REQ-022 cpha=0: MOSI SHALL present bit DATA_W-1 from the first LEAD cycle; MISO sampled on leading (odd) edges; MOSI advances on trailing edges.
REQ-023 cpha=1: MOSI SHALL advance on leading edges (first bit presented at edge 1); MISO sampled on trailing (even) edges.
REQ-024 TRAIL SHALL last CLKDIV cycles with SS still asserted, then enter DONE.
REQ-025 In DONE (one cycle): all spi0_SS_n=1, done=1, busy=0, rx_data updated to the assembled word; next state IDLE.
REQ-026 For a start accepted in cycle 0, done SHALL be high in cycle 1+CLKDIV*(2*DATA_W+2).
REQ-027 A start asserted during the DONE cycle SHALL be accepted as if in IDLE (back-to-back transfers).
REQ-028 rx_data SHALL change only in DONE; intermediate shift bits SHALL not be visible.
REQ-029 At most one spi0_SS_n bit SHALL be low at any time.
REQ-030 In IDLE, spi0_SCLK SHALL equal the cpol of the last accepted transfer (0 after reset); spi0_MOSI=0.

Reset
REQ-031 reset_reset=1 SHALL asynchronously force state IDLE, busy=0, done=0, err=0, rx_data=0, spi0_SCLK=0, spi0_MOSI=0, spi0_SS_n all 1, clock divider and bit counters 0.
REQ-032 Reset mid-transfer SHALL abort without a done pulse; first start after release SHALL behave as after power-up.

Verification
REQ-033 DATA_W=8, CLKDIV=2, mode 0, tx 0xA5, MISO looped to MOSI -> 16 SCLK edges, rx_data=0xA5, done at cycle 37, SS_n[0] low cycles 1..36.
REQ-034 Mode 3 (cpol=1, cpha=1), tx 0x3C, MISO driven by a slave model returning 0xC3 -> SCLK idles high, rx_data=0xC3.
REQ-035 NUM_SS=2, start with ss_sel=3 (2-bit port via override) -> err=1 one cycle, busy stays 0, SS_n=2'b11.
REQ-036 start pulsed again at cycle 10 of a transfer -> ignored; single done, rx_data from first transfer only.
REQ-037 reset_reset asserted at cycle 20 of a transfer -> SS_n all 1, SCLK 0, busy 0 immediately; no done pulse.
REQ-038 start held through DONE with ss_sel=1 -> second transfer starts the cycle after done, SS_n=2'b01.

Source files
------------

// File: rtl/spi_master_multi.sv
// SPI master with selectable slave, per-transfer SPI mode (cpol/cpha) and
// fixed SCLK divider. One word of DATA_W bits is exchanged MSB first per
// accepted start; the received word is published only when the transfer ends.
module spi_master_multi #(
    parameter int DATA_W = 8,
    parameter int NUM_SS = 2,
    parameter int CLKDIV = 4,
    parameter int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [SS_W-1:0]   ss_sel,
    input  logic              cpol,
    input  logic              cpha,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rx_data,
    output logic              spi0_SCLK,
    output logic              spi0_MOSI,
    input  logic              spi0_MISO,
    output logic [NUM_SS-1:0] spi0_SS_n
);

    localparam int DIV_W  = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLKDIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W);
    localparam logic [SS_W:0]     SS_LIMIT  = NUM_SS[SS_W:0];

    typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SHIFT, S_TRAIL, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DIV_W-1:0]    r_div;
    logic [EDGE_W-1:0]   r_edge;
    logic [DATA_W-1:0]   r_tx;
    logic [DATA_W-1:0]   r_rx;
    logic [DATA_W-1:0]   r_rx_data;
    logic [SS_W-1:0]     r_ss;
    logic                r_cpha;
    logic                r_sclk;
    logic                r_mosi;
    logic                r_err;
    logic                w_tick;
    logic                w_accept;
    logic                w_reject;
    logic                w_edge;
    logic                w_sample;

    assign spi0_SCLK = r_sclk;
    assign spi0_MOSI = r_mosi;
    assign err       = r_err;
    assign rx_data   = r_rx_data;

    // Edge n+1 is leading when r_edge is even; sample on leading for cpha=0,
    // on trailing for cpha=1, and shift MOSI on the other edge.
    assign w_sample = (r_edge[0] == r_cpha);

    // State register
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic, request decode, SCLK edge generation and status outputs
    always_comb begin
        w_state_nxt = r_state;
        w_tick      = (r_div == DIV_LAST);
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_edge      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                done        = (r_state == S_DONE);
                w_state_nxt = S_IDLE;
                if (start) begin
                    if ({1'b0, ss_sel} < SS_LIMIT) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_LEAD;
                    end else begin
                        w_reject    = 1'b1;
                    end
                end
            end
            S_LEAD: begin
                busy = 1'b1;
                if (w_tick) begin
                    w_edge      = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (w_tick) begin
                    // The last divider period after edge 2*DATA_W carries no edge.
                    if (r_edge == EDGE_LAST) begin
                        w_state_nxt = S_TRAIL;
                    end else begin
                        w_edge = 1'b1;
                    end
                end
            end
            S_TRAIL: begin
                busy = 1'b1;
                if (w_tick) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Transfer datapath: latch request, divide clock, shift both directions
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_div     <= '0;
            r_edge    <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rx_data <= '0;
            r_ss      <= '0;
            r_cpha    <= 1'b0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_reject;
            if (w_accept) begin
                r_div  <= '0;
                r_edge <= '0;
                r_ss   <= ss_sel;
                r_cpha <= cpha;
                r_sclk <= cpol;
                r_rx   <= '0;
                // cpha=0 puts the MSB on the line immediately; cpha=1 waits for edge 1.
                if (cpha) begin
                    r_tx   <= tx_data;
                    r_mosi <= 1'b0;
                end else begin
                    r_tx   <= {tx_data[DATA_W-2:0], 1'b0};
                    r_mosi <= tx_data[DATA_W-1];
                end
            end else if (busy) begin
                r_div <= w_tick ? '0 : r_div + 1'b1;
                if (w_edge) begin
                    r_edge <= r_edge + 1'b1;
                    r_sclk <= ~r_sclk;
                    if (w_sample) begin
                        r_rx <= {r_rx[DATA_W-2:0], spi0_MISO};
                    end else begin
                        r_mosi <= r_tx[DATA_W-1];
                        r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
                    end
                end
                if (w_state_nxt == S_DONE) begin
                    r_rx_data <= r_rx;
                    r_mosi    <= 1'b0;
                end
            end else begin
                r_mosi <= 1'b0;
            end
        end
    end

    // One-hot active-low slave select, only while a transfer is in progress
    always_comb begin
        spi0_SS_n = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            if (busy && (r_ss == SS_W'(i))) begin
                spi0_SS_n[i] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi: DATA_W=8, NUM_SS=2, CLKDIV=2, 2-bit ss_sel.
// MISO is looped back from MOSI, or driven by a small mode-3 slave model.
module tb_spi_master_multi;

    localparam int DW   = 8;
    localparam int DONE_CYC = 1 + 2 * (2 * DW + 2);   // 37

    logic       clk_clk = 1'b0;
    logic       reset_reset;
    logic       start;
    logic [7:0] tx_data;
    logic [1:0] ss_sel;
    logic       cpol;
    logic       cpha;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] rx_data;
    logic       spi0_SCLK;
    logic       spi0_MOSI;
    logic       spi0_MISO;
    logic [1:0] spi0_SS_n;

    int checks = 0;
    int errors = 0;

    // slave model / observers
    logic       slave_en;
    logic [7:0] slave_word;
    logic       slave_bit;
    int         neg_cnt = 0;
    int         neg_base;
    int         k;
    int         edge_cnt = 0;

    spi_master_multi #(.DATA_W(8), .NUM_SS(2), .CLKDIV(2), .SS_W(2)) dut (
        .clk_clk    (clk_clk),
        .reset_reset(reset_reset),
        .start      (start),
        .tx_data    (tx_data),
        .ss_sel     (ss_sel),
        .cpol       (cpol),
        .cpha       (cpha),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .rx_data    (rx_data),
        .spi0_SCLK  (spi0_SCLK),
        .spi0_MOSI  (spi0_MOSI),
        .spi0_MISO  (spi0_MISO),
        .spi0_SS_n  (spi0_SS_n)
    );

    always #5 clk_clk = ~clk_clk;

    always @(spi0_SCLK) edge_cnt <= edge_cnt + 1;
    always @(negedge spi0_SCLK) neg_cnt <= neg_cnt + 1;

    // Mode-3 slave: presents next bit on each leading (falling) SCLK edge.
    always_comb begin
        k = neg_cnt - neg_base;
        slave_bit = 1'b0;
        if (k >= 1 && k <= 8) slave_bit = slave_word[8 - k];
    end

    assign spi0_MISO = slave_en ? slave_bit : spi0_MOSI;

    typedef struct {
        logic       c_pol;
        logic       c_pha;
        logic [7:0] tx;
        logic [1:0] ss;
        logic       slv;
        logic [7:0] slv_word;
        logic [7:0] exp_rx;
        logic [1:0] exp_ssn;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Launch one transfer and run to its done cycle (bounded); stays in the done cycle.
    task automatic run_xfer(input logic c_pol, input logic c_pha, input logic [7:0] tx,
                            input logic [1:0] ss, input logic [1:0] exp_ssn,
                            output int done_cyc, output int ss_bad, output int rx_bad,
                            output int edges);
        logic [7:0] rx_prev;
        int e0;
        rx_prev  = rx_data;
        cpol     = c_pol;
        cpha     = c_pha;
        tx_data  = tx;
        ss_sel   = ss;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        e0       = edge_cnt;
        done_cyc = -1;
        ss_bad   = 0;
        rx_bad   = 0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (!busy || spi0_SS_n !== exp_ssn) ss_bad++;
            if (rx_data !== rx_prev) rx_bad++;
            tick();
        end
        edges = edge_cnt - e0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int dc, sb, rb, ed;
        int n_done, n_err, n_ss1, n_busy;
        logic [7:0] rx_first;
        logic sclk_before;

        vecs[0] = '{1'b0, 1'b0, 8'hA5, 2'd0, 1'b0, 8'h00, 8'hA5, 2'b10};
        vecs[1] = '{1'b1, 1'b1, 8'h3C, 2'd0, 1'b1, 8'hC3, 8'hC3, 2'b10};
        vecs[2] = '{1'b0, 1'b1, 8'h96, 2'd1, 1'b0, 8'h00, 8'h96, 2'b01};
        vecs[3] = '{1'b1, 1'b0, 8'h0F, 2'd1, 1'b0, 8'h00, 8'h0F, 2'b01};
        vecs[4] = '{1'b1, 1'b1, 8'h7E, 2'd1, 1'b1, 8'h81, 8'h81, 2'b01};

        reset_reset = 1'b1;
        start = 1'b0; tx_data = '0; ss_sel = '0; cpol = 1'b0; cpha = 1'b0;
        slave_en = 1'b0; slave_word = '0; neg_base = 0;
        tick(); tick();

        // reset state
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rx", rx_data, 0);
        chk("rst_sclk", spi0_SCLK, 0);
        chk("rst_mosi", spi0_MOSI, 0);
        chk("rst_ss_n", spi0_SS_n, 2'b11);
        @(negedge clk_clk);
        reset_reset = 1'b0;
        tick();

        // table-driven transfers
        for (int i = 0; i < 5; i++) begin
            slave_en   = vecs[i].slv;
            slave_word = vecs[i].slv_word;
            neg_base   = neg_cnt;
            run_xfer(vecs[i].c_pol, vecs[i].c_pha, vecs[i].tx, vecs[i].ss, vecs[i].exp_ssn,
                     dc, sb, rb, ed);
            chk($sformatf("v%0d_done_cycle", i), dc, DONE_CYC);
            chk($sformatf("v%0d_rx", i), rx_data, vecs[i].exp_rx);
            chk($sformatf("v%0d_ss_during", i), sb, 0);
            chk($sformatf("v%0d_rx_stable", i), rb, 0);
            chk($sformatf("v%0d_edges", i), ed, 16);
            chk($sformatf("v%0d_sclk_idle", i), spi0_SCLK, vecs[i].c_pol);
            chk($sformatf("v%0d_ss_at_done", i), spi0_SS_n, 2'b11);
            chk($sformatf("v%0d_busy_at_done", i), busy, 0);
            tick();
            chk($sformatf("v%0d_mosi_idle", i), spi0_MOSI, 0);
            chk($sformatf("v%0d_done_one_cycle", i), done, 0);
        end
        slave_en = 1'b0;

        // rejected request: ss_sel beyond NUM_SS
        sclk_before = spi0_SCLK;
        ss_sel = 2'd3; tx_data = 8'h11; cpol = ~sclk_before; cpha = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("bad_ss_err", err, 1);
        chk("bad_ss_busy", busy, 0);
        chk("bad_ss_ss_n", spi0_SS_n, 2'b11);
        chk("bad_ss_sclk", spi0_SCLK, sclk_before);
        tick();
        chk("bad_ss_err_pulse", err, 0);
        chk("bad_ss_busy2", busy, 0);

        // start during busy is ignored
        cpol = 1'b0; cpha = 1'b0; tx_data = 8'h5A; ss_sel = 2'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_done = 0; n_err = 0; n_ss1 = 0; rx_first = '0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            if (cyc == 10) begin start = 1'b1; tx_data = 8'hFF; ss_sel = 2'd1; end
            if (cyc == 11) start = 1'b0;
            if (done) begin
                n_done++;
                if (n_done == 1) rx_first = rx_data;
            end
            if (err) n_err++;
            if (spi0_SS_n[1] == 1'b0) n_ss1++;
            tick();
        end
        chk("ign_done_count", n_done, 1);
        chk("ign_rx", rx_first, 8'h5A);
        chk("ign_rx_final", rx_data, 8'h5A);
        chk("ign_no_err", n_err, 0);
        chk("ign_no_ss1", n_ss1, 0);

        // asynchronous reset mid-transfer
        cpol = 1'b0; cpha = 1'b0; tx_data = 8'hE7; ss_sel = 2'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc < 20; cyc++) tick();
        chk("pre_rst_sclk_high", spi0_SCLK, 1);
        #2;
        reset_reset = 1'b1;
        #1;
        chk("mid_rst_ss_n", spi0_SS_n, 2'b11);
        chk("mid_rst_sclk", spi0_SCLK, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rx", rx_data, 0);
        tick(); tick();
        @(negedge clk_clk);
        reset_reset = 1'b0;
        n_done = 0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (done) n_done++;
            tick();
        end
        chk("mid_rst_no_done", n_done, 0);
        run_xfer(1'b0, 1'b0, 8'h69, 2'd0, 2'b10, dc, sb, rb, ed);
        chk("post_rst_done_cycle", dc, DONE_CYC);
        chk("post_rst_rx", rx_data, 8'h69);
        tick();

        // back-to-back: start held through DONE
        cpol = 1'b0; cpha = 1'b0; tx_data = 8'h33; ss_sel = 2'd0;
        start = 1'b1;
        tick();
        tx_data = 8'hCC; ss_sel = 2'd1;
        dc = -1; n_err = 0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            if (done) begin dc = cyc; break; end
            if (err) n_err++;
            tick();
        end
        chk("b2b_first_done_cycle", dc, DONE_CYC);
        chk("b2b_first_rx", rx_data, 8'h33);
        chk("b2b_no_err", n_err, 0);
        tick();
        start = 1'b0;
        chk("b2b_second_busy", busy, 1);
        chk("b2b_second_ss_n", spi0_SS_n, 2'b01);
        dc = -1; n_busy = 0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            if (done) begin dc = cyc; break; end
            if (spi0_SS_n !== 2'b01) n_busy++;
            tick();
        end
        chk("b2b_second_done_cycle", dc, DONE_CYC);
        chk("b2b_second_rx", rx_data, 8'hCC);
        chk("b2b_second_ss_steady", n_busy, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
